piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 135 +++++++++++++
 tb/tb_piso_serializer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out shifter with valid/ready handshakes on both sides.
// A word is accepted on load_valid && load_ready. Its bits are then presented
// one at a time on ser_out, in MSB-first or LSB-first order as selected at load
// time. Each bit is held until the downstream consumes it with
// ser_valid && ser_ready.
//
// Loading again in the same cycle as the last bit is consumed gives
// back-to-back words with no idle cycle between them.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   data_in    : parallel word to serialize (WIDTH bits)
//   msb_first  : bit order captured with the word (1 = MSB first, 0 = LSB first)
//   load_valid : upstream offers data_in / msb_first
//   load_ready : a word can be accepted this cycle
//   ser_ready  : downstream accepts the current serial bit
//   ser_out    : current serial bit (0 when idle)
//   ser_valid  : ser_out holds a valid bit
//   ser_last   : current bit is the final bit of its word
//   busy       : a word is in progress (same as ser_valid)
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             msb_first,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q,    state_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [WIDTH-1:0] word_q,     word_d;
    logic             msb_q,      msb_d;
    logic             ser_out_q,  ser_out_d;
    logic             ser_last_q, ser_last_d;

    logic load_fire;
    logic bit_fire;

    // Bit of word w that is emitted at position c for the given order.
    function automatic logic pick_bit(input logic [WIDTH-1:0] w,
                                      input logic             msb,
                                      input logic [CW-1:0]    c);
        logic [CW-1:0] idx;
        idx = msb ? (CNT_MAX - c) : c;
        return w[idx];
    endfunction

    assign ser_valid = (state_q == SHIFT);
    assign busy      = ser_valid;
    assign ser_out   = ser_out_q;
    assign ser_last  = ser_last_q;

    // A reload is only possible while the last bit is being consumed, so a
    // load in SHIFT always coincides with the end of the current word.
    assign load_ready = (state_q == IDLE) || (ser_last_q && ser_ready);

    assign load_fire = load_valid && load_ready;
    assign bit_fire  = ser_valid && ser_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        msb_d      = msb_q;
        ser_out_d  = ser_out_q;
        ser_last_d = ser_last_q;

        if (load_fire) begin
            state_d    = SHIFT;
            cnt_d      = '0;
            word_d     = data_in;
            msb_d      = msb_first;
            ser_out_d  = pick_bit(data_in, msb_first, '0);
            ser_last_d = (CNT_MAX == '0);
        end else if (bit_fire) begin
            if (ser_last_q) begin
                // Word finished and nothing new loaded: go quiet, drive 0.
                state_d    = IDLE;
                cnt_d      = '0;
                ser_out_d  = 1'b0;
                ser_last_d = 1'b0;
            end else begin
                cnt_d      = cnt_q + CW'(1);
                ser_out_d  = pick_bit(word_q, msb_q, cnt_d);
                ser_last_d = (cnt_d == CNT_MAX);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the captured word is reset too; it is a single register,
            // not a memory, and must read 0 while in reset.
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            msb_q      <= 1'b0;
            ser_out_q  <= 1'b0;
            ser_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            msb_q      <= msb_d;
            ser_out_q  <= ser_out_d;
            ser_last_q <= ser_last_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Self-checking bench for piso_serializer (WIDTH = 4). The reference model is
// a queue holding the bits still to be sent for the current word: the head is
// the bit on ser_out, a consumed bit is popped, and a load pushes the new word
// in its chosen order. Directed sequences also compare the consumed bits
// against literal expected streams.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         msb_first = 1'b0;
    logic         load_valid = 1'b0;
    logic         ser_ready = 1'b0;
    logic         load_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_last;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    bit exp_q[$];   // model: bits of the current word not yet consumed
    bit got_q[$];   // bits actually consumed from the DUT

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .msb_first  (msb_first),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_ready  (ser_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model, then advance the model at the rising edge.
    task automatic cyc(input bit lv, input logic [W-1:0] d, input bit m, input bit sr);
        bit ev, eo, el, elr;
        @(negedge clk);
        load_valid = lv;
        data_in    = d;
        msb_first  = m;
        ser_ready  = sr;
        #1;
        ev  = (exp_q.size() > 0);
        eo  = ev ? exp_q[0] : 1'b0;
        el  = (exp_q.size() == 1);
        elr = !ev || (el && sr);
        check("ser_valid",  ser_valid,  ev);
        check("busy",       busy,       ev);
        check("ser_out",    ser_out,    eo);
        check("ser_last",   ser_last,   el);
        check("load_ready", load_ready, elr);
        if (ser_valid && sr) got_q.push_back(ser_out);
        @(posedge clk);
        if (ev && sr) void'(exp_q.pop_front());
        if (lv && elr) begin
            for (int i = 0; i < W; i++)
                exp_q.push_back(m ? d[W-1-i] : d[i]);
        end
    endtask

    // Compare the consumed stream with n bits of seq, first bit = seq[n-1].
    task automatic expect_seq(input string tag, input logic [7:0] seq, input int n);
        check({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            check(tag, got_q[i], seq[n-1-i]);
        got_q.delete();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, observed while rst_n is still low.
        #12;
        check("rst_ser_valid",  ser_valid,  1'b0);
        check("rst_ser_out",    ser_out,    1'b0);
        check("rst_ser_last",   ser_last,   1'b0);
        check("rst_busy",       busy,       1'b0);
        check("rst_load_ready", load_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // MSB first, ser_ready held high.
        got_q.delete();
        cyc(1'b1, 4'b1011, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0000, 1'b0, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0, 1'b1);
        expect_seq("msb_1011", 8'b1011, 4);

        // LSB first.
        cyc(1'b1, 4'b1011, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'b1111, 1'b1, 1'b1);
        expect_seq("lsb_1011", 8'b1101, 4);

        // Stalls: ser_ready 1,0,0,1,1,0,1, input noise while busy.
        cyc(1'b1, 4'b0110, 1'b1, 1'b0);
        begin
            bit [6:0] pat;
            pat = 7'b1001101;
            for (int i = 6; i >= 0; i--) cyc(1'b0, W'($urandom), 1'($urandom), pat[i]);
        end
        cyc(1'b0, 4'b0000, 1'b0, 1'b1);
        expect_seq("stall_0110", 8'b0110, 4);

        // Back-to-back reload with load_valid held high.
        cyc(1'b1, 4'hA, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'h5, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b1, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        expect_seq("b2b_A5", 8'b1010_0101, 8);

        // Reset in the middle of a word.
        cyc(1'b1, 4'hF, 1'b1, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        @(negedge clk);
        load_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ser_valid",  ser_valid,  1'b0);
        check("midrst_ser_out",    ser_out,    1'b0);
        check("midrst_ser_last",   ser_last,   1'b0);
        check("midrst_busy",       busy,       1'b0);
        check("midrst_load_ready", load_ready, 1'b1);
        exp_q.delete();
        got_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 4'h1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'hE, 1'b1, 1'b1);
        expect_seq("after_rst_1", 8'b1000, 4);

        // Captured word immune to input changes while shifting.
        cyc(1'b1, 4'b1100, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, W'($urandom), 1'($urandom), 1'b1);
        expect_seq("hold_1100", 8'b0011, 4);

        // Randomised traffic checked against the queue model.
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 2) != 0), W'($urandom), 1'($urandom),
                1'($urandom_range(0, 3) != 0));
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
